// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready output stage.
// Multi-cycle ops (MUL/DIV) hold the stage busy for MULTI_LAT cycles.
module alu_control_seq #(
   parameter int OPCODE_W   = 2,
   parameter int FUNCT_W    = 4,
   parameter int ALU_CODE_W = 4,
   parameter int MULTI_LAT  = 4,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OPCODE_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0]    function_code,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ALU_CODE_W-1:0] alu_code,
   output logic                  is_imm,
   output logic                  is_multi,
   output logic                  illegal,
   output logic                  busy,
   output logic [CNT_W-1:0]      illegal_count
);

   localparam int LAT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [LAT_W-1:0] cnt, cnt_d;

   logic       op_hi, fn_hi, accept;
   logic [3:0] d_code;
   logic       d_imm, d_multi, d_ill;

   // Bits beyond the decoded fields must be zero for a legal op
   assign op_hi = (opcode >> 2) != '0;
   assign fn_hi = (function_code >> 4) != '0;

   always_comb begin
      d_code  = 4'd0;
      d_imm   = 1'b0;
      d_multi = 1'b0;
      d_ill   = 1'b0;
      if (op_hi) begin
         d_ill = 1'b1;
      end else begin
         unique case (opcode[1:0])
            2'b01: d_code = 4'd1;
            2'b10: d_code = 4'd2;
            2'b11: d_ill  = 1'b1;
            default: begin
               if (fn_hi) begin
                  d_ill = 1'b1;
               end else begin
                  unique case (function_code[3:0])
                     4'd0: d_code = 4'd0;
                     4'd1: d_code = 4'd1;
                     4'd2: d_code = 4'd2;
                     4'd3: d_code = 4'd3;
                     4'd4: d_code = 4'd4;
                     4'd5: d_code = 4'd5;
                     4'd6: begin d_code = 4'd1; d_imm = 1'b1; end
                     4'd7: begin d_code = 4'd2; d_imm = 1'b1; end
                     4'd8: begin d_code = 4'd0; d_imm = 1'b1; end
                     4'd9: begin d_code = 4'd9; d_multi = 1'b1; end
                     4'd10: begin d_code = 4'd10; d_multi = 1'b1; end
                     default: d_ill = 1'b1;
                  endcase
               end
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE) || ((state == VALID) && out_ready);
   assign out_valid = (state == VALID);
   assign busy      = (state == BUSY);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         BUSY: begin
            if (cnt == '0) state_d = VALID;
            else           cnt_d   = cnt - LAT_W'(1);
         end
         VALID: begin
            if (out_ready && !in_valid) state_d = IDLE;
         end
         default: ;
      endcase
      // A new op overrides the hold/retire decision above
      if (accept) begin
         if (d_multi) begin
            state_d = BUSY;
            cnt_d   = LAT_W'(MULTI_LAT - 1);
         end else begin
            state_d = VALID;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         alu_code      <= '0;
         is_imm        <= 1'b0;
         is_multi      <= 1'b0;
         illegal       <= 1'b0;
         illegal_count <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (accept) begin
            alu_code <= ALU_CODE_W'(d_code);
            is_imm   <= d_imm;
            is_multi <= d_multi;
            illegal  <= d_ill;
            if (d_ill && (illegal_count != '1))
               illegal_count <= illegal_count + CNT_W'(1);
         end
      end
   end

endmodule
